// File: rtl/aud_pkg.sv
// rtl/aud_pkg.sv - shared types and constants for the audio SRAM writer
package aud_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_WRITE = 2'd2,
        S_HOLD  = 2'd3
    } wr_state_e;

    typedef logic [19:0]        sram_addr_t;
    typedef logic signed [15:0] sample_t;

    typedef struct packed {
        sram_addr_t addr;
        sample_t    data;
    } wr_entry_t;

    localparam int      ENTRY_W  = $bits(wr_entry_t);
    localparam sample_t CLIP_POS = 16'sh7FFF;
    localparam sample_t CLIP_NEG = 16'sh8000;

    // Full-scale samples in either direction count as clipped
    function automatic logic is_clip(input sample_t s);
        return (s == CLIP_POS) || (s == CLIP_NEG);
    endfunction

endpackage

// File: rtl/aud_sync_fifo.sv
// rtl/aud_sync_fifo.sv - small synchronous FIFO with flush, clocked on negedge
module aud_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign o_full  = (count_q == (AW+1)'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_data  = mem_q[rd_ptr_q];

    // Flush wins over everything; a push into a full FIFO is taken only when a pop frees a slot
    always_comb begin
        pop_ok   = i_pop && !o_empty && !i_flush;
        push_ok  = i_push && (!o_full || pop_ok) && !i_flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    // Pointer and occupancy registers
    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy decides what is valid
    always_ff @(negedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_data;
    end

endmodule

// File: rtl/aud_sram_writer.sv
// rtl/aud_sram_writer.sv - recorder-to-SRAM sample writer; AUD_CLIP_DETECT_EN adds o_clip_cnt
module aud_sram_writer
    import aud_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter int         WE_CYCLES  = 2,
    parameter sram_addr_t MAX_ADDR   = 20'd1024000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rec_start,
    input  logic [19:0] i_rec_addr,
    input  logic [15:0] i_rec_data,
    output logic [19:0] o_sram_addr,
    output logic [15:0] o_sram_dq,
    output logic        o_sram_dq_oe,
    output logic        o_sram_we_n,
    output logic        o_sram_ce_n,
    output logic        o_sram_oe_n,
    output logic        o_sram_lb_n,
    output logic        o_sram_ub_n,
    output logic [19:0] o_rec_len,
    output logic        o_busy,
    output logic        o_overflow
`ifdef AUD_CLIP_DETECT_EN
    ,
    output logic [15:0] o_clip_cnt
`endif
);

    localparam int CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    sram_addr_t        prev_addr_q, prev_addr_d;
    logic              det_valid_q, det_valid_d;
    wr_entry_t         det_entry_q, det_entry_d;
    wr_state_e         state_q, state_d;
    logic [CNT_W-1:0]  we_cnt_q, we_cnt_d;
    sram_addr_t        addr_q, addr_d;
    sample_t           dq_q, dq_d;
    logic              ce_n_q, ce_n_d;
    logic              we_n_q, we_n_d;
    logic              be_n_q, be_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic [19:0]       rec_len_q, rec_len_d;
    logic              overflow_q, overflow_d;
    logic              counts_q, counts_d;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    wr_entry_t         fifo_rdata;
    logic              word_done;

    // A word is complete when the recorder moves to any other address; the word belongs to the old one
    always_comb begin
        prev_addr_d = prev_addr_q;
        det_valid_d = 1'b0;
        det_entry_d = det_entry_q;
        if (i_rec_start) begin
            prev_addr_d = i_rec_addr;
        end else if (i_rec_addr != prev_addr_q) begin
            prev_addr_d = i_rec_addr;
            det_valid_d = (prev_addr_q <= MAX_ADDR);
            det_entry_d = '{addr: prev_addr_q, data: sample_t'(i_rec_data)};
        end
    end

    assign fifo_push = det_valid_q && !i_rec_start;

    aud_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_rec_start),
        .i_push  (fifo_push),
        .i_data  (det_entry_q),
        .i_pop   (fifo_pop),
        .o_data  (fifo_rdata),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // Write sequencer: setup, WE_CYCLES of strobe, one hold, then back to idle; pins follow next state
    always_comb begin
        state_d  = state_q;
        we_cnt_d = we_cnt_q;
        addr_d   = addr_q;
        dq_d     = dq_q;
        counts_d = counts_q;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !i_rec_start) begin
                    fifo_pop = 1'b1;
                    addr_d   = fifo_rdata.addr;
                    dq_d     = fifo_rdata.data;
                    counts_d = 1'b1;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                we_cnt_d = '0;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                if (we_cnt_q == CNT_W'(WE_CYCLES - 1)) begin
                    state_d = S_HOLD;
                end else begin
                    we_cnt_d = we_cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // An in-flight write finishes after a new recording starts but is not credited to it
        if (i_rec_start) counts_d = 1'b0;
        ce_n_d  = (state_d == S_IDLE);
        dq_oe_d = (state_d != S_IDLE);
        we_n_d  = (state_d != S_WRITE);
        be_n_d  = (state_d != S_WRITE);
    end

    assign word_done = (state_q == S_HOLD) && counts_q && !i_rec_start;

    // Record length and sticky overflow status
    always_comb begin
        rec_len_d  = rec_len_q;
        overflow_d = overflow_q;
        if (i_rec_start) begin
            rec_len_d  = '0;
            overflow_d = 1'b0;
        end else begin
            if (word_done && (rec_len_q != '1)) rec_len_d = rec_len_q + 20'd1;
            if (fifo_push && fifo_full && !fifo_pop) overflow_d = 1'b1;
        end
    end

    // All state registers; reset parks the SRAM pins inactive at once
    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_addr_q <= '0;
            det_valid_q <= 1'b0;
            det_entry_q <= '0;
            state_q     <= S_IDLE;
            we_cnt_q    <= '0;
            addr_q      <= '0;
            dq_q        <= '0;
            ce_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            be_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            rec_len_q   <= '0;
            overflow_q  <= 1'b0;
            counts_q    <= 1'b0;
        end else begin
            prev_addr_q <= prev_addr_d;
            det_valid_q <= det_valid_d;
            det_entry_q <= det_entry_d;
            state_q     <= state_d;
            we_cnt_q    <= we_cnt_d;
            addr_q      <= addr_d;
            dq_q        <= dq_d;
            ce_n_q      <= ce_n_d;
            we_n_q      <= we_n_d;
            be_n_q      <= be_n_d;
            dq_oe_q     <= dq_oe_d;
            rec_len_q   <= rec_len_d;
            overflow_q  <= overflow_d;
            counts_q    <= counts_d;
        end
    end

`ifdef AUD_CLIP_DETECT_EN
    logic [15:0] clip_cnt_q, clip_cnt_d;

    // Count full-scale words as they complete, saturating
    always_comb begin
        clip_cnt_d = clip_cnt_q;
        if (i_rec_start) begin
            clip_cnt_d = '0;
        end else if (word_done && is_clip(dq_q) && (clip_cnt_q != 16'hFFFF)) begin
            clip_cnt_d = clip_cnt_q + 16'd1;
        end
    end

    // Clip counter register
    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) clip_cnt_q <= '0;
        else          clip_cnt_q <= clip_cnt_d;
    end

    assign o_clip_cnt = clip_cnt_q;
`endif

    assign o_sram_addr  = addr_q;
    assign o_sram_dq    = dq_q;
    assign o_sram_dq_oe = dq_oe_q;
    assign o_sram_we_n  = we_n_q;
    assign o_sram_ce_n  = ce_n_q;
    assign o_sram_oe_n  = 1'b1;
    assign o_sram_lb_n  = be_n_q;
    assign o_sram_ub_n  = be_n_q;
    assign o_rec_len    = rec_len_q;
    assign o_overflow   = overflow_q;
    assign o_busy       = !fifo_empty || (state_q != S_IDLE);

endmodule
